// File: rtl/regarr_pkg.sv
// Shared constants and types for the register-array controller.
package regarr_pkg;

  localparam int ROWS = 12;
  localparam int COLS = 12;
  localparam int DW   = 36;
  localparam int AW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

endpackage

// File: rtl/regarr_rd_fifo.sv
// Two-entry read buffer: absorbs array read data while the consumer stalls.
module regarr_rd_fifo
  import regarr_pkg::*;
#(
  parameter int WIDTH = DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; the controller never pushes into a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/regarr_ctrl.sv
// Register-array controller: streams a full matrix in (row-major) and reads it
// back out row-major or column-major through a small credit-limited buffer.
module regarr_ctrl
  import regarr_pkg::*;
#(
  parameter int ROWS = regarr_pkg::ROWS,
  parameter int COLS = regarr_pkg::COLS,
  parameter int DW   = regarr_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_start,
  input  logic          rd_start,
  input  logic          rd_transpose,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          wr_done,
  output logic [AW-1:0] arr_addr_row,
  output logic [AW-1:0] arr_addr_col,
  output logic [DW-1:0] arr_data_in,
  output logic          arr_write_en,
  output logic          arr_read_en,
  input  logic [DW-1:0] arr_data_out
);

  localparam int TOTAL = ROWS * COLS;
  localparam int CW    = $clog2(TOTAL + 1);

  state_t        state;
  logic [AW-1:0] wr_row, wr_col;
  logic [AW-1:0] rd_row, rd_col;
  logic          xpose;
  logic [CW-1:0] rd_issued;
  logic [CW-1:0] rd_popped;
  logic          inflight;

  logic          wr_beat, wr_last;
  logic          rd_issue, pop, all_issued, out_last;
  logic [2:0]    occupancy;
  logic          fifo_valid;
  logic [DW-1:0] fifo_head;
  logic [1:0]    fifo_count;

  assign wr_beat    = (state == LOAD) && s_valid;
  assign wr_last    = (wr_row == AW'(ROWS - 1)) && (wr_col == AW'(COLS - 1));
  assign pop        = fifo_valid && m_ready;
  assign all_issued = (rd_issued == CW'(TOTAL));
  assign out_last   = (rd_popped == CW'(TOTAL - 1));
  // Buffer slots already claimed (held + in flight) after this cycle's pop.
  assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign rd_issue   = (state == READ) && !all_issued && (occupancy < 3'd2);

  // Single FSM: mode changes, address walkers, counters and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      xpose     <= 1'b0;
      rd_issued <= '0;
      rd_popped <= '0;
      inflight  <= 1'b0;
    end else begin
      wr_done  <= 1'b0;
      inflight <= rd_issue;
      case (state)
        IDLE: begin
          if (wr_start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            wr_row  <= '0;
            wr_col  <= '0;
          end else if (rd_start) begin
            state     <= READ;
            busy      <= 1'b1;
            xpose     <= rd_transpose;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_issued <= '0;
            rd_popped <= '0;
          end
        end
        LOAD: begin
          if (wr_beat) begin
            if (wr_last) begin
              state   <= IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              wr_done <= 1'b1;
              wr_row  <= '0;
              wr_col  <= '0;
            end else if (wr_col == AW'(COLS - 1)) begin
              wr_col <= '0;
              wr_row <= wr_row + 1'b1;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            rd_issued <= rd_issued + 1'b1;
            if (!xpose) begin
              if (rd_col == AW'(COLS - 1)) begin
                rd_col <= '0;
                rd_row <= rd_row + 1'b1;
              end else begin
                rd_col <= rd_col + 1'b1;
              end
            end else begin
              if (rd_row == AW'(ROWS - 1)) begin
                rd_row <= '0;
                rd_col <= rd_col + 1'b1;
              end else begin
                rd_row <= rd_row + 1'b1;
              end
            end
          end
          if (pop) begin
            rd_popped <= rd_popped + 1'b1;
            if (out_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  regarr_rd_fifo #(
    .WIDTH (DW)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (arr_data_out),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign m_valid      = fifo_valid;
  assign m_data       = fifo_head;
  assign m_last       = fifo_valid && out_last;
  assign arr_write_en = wr_beat;
  assign arr_read_en  = rd_issue;
  assign arr_data_in  = wr_beat ? s_data : '0;
  assign arr_addr_row = wr_beat ? wr_row : (rd_issue ? rd_row : '0);
  assign arr_addr_col = wr_beat ? wr_col : (rd_issue ? rd_col : '0);

endmodule
